// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register for the LEGv8 pipeline.
// Latches the ALU result, destination and downstream control bits, and owns
// the architectural NZCV register plus the committed-instruction counter.
// flags_fwd lets a B.cond in EX see flags being produced this same cycle.
module ex_mem_latch #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [DATA_WIDTH-1:0]     result,
  input  logic                      negative,
  input  logic                      zero,
  input  logic                      overflow,
  input  logic                      carry_out,
  input  logic                      set_flags,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  input  logic                      reg_write,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic                      mem_to_reg,
  input  logic [DATA_WIDTH-1:0]     store_data,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_result,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic                      out_reg_write,
  output logic                      out_mem_read,
  output logic                      out_mem_write,
  output logic                      out_mem_to_reg,
  output logic [DATA_WIDTH-1:0]     out_store_data,
  output logic [3:0]                flags,
  output logic [3:0]                flags_fwd,
  output logic [COUNT_WIDTH-1:0]    commit_count
);

  // Downstream control bundle; kept together so gating and squashing are uniform.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

  ctrl_t      ctrl_q;
  ctrl_t      ctrl_in;
  logic [3:0] nzcv_in;
  logic       flag_upd;

  // Architectural NZCV ordering: N, Z, C, V from bit3 down to bit0.
  assign nzcv_in  = {negative, zero, carry_out, overflow};
  assign flag_upd = in_valid & set_flags;

  // Gate control with in_valid so a bubble can never write a register or memory.
  assign ctrl_in = '{reg_write:  reg_write  & in_valid,
                     mem_read:   mem_read   & in_valid,
                     mem_write:  mem_write  & in_valid,
                     mem_to_reg: mem_to_reg & in_valid};

  // Pipeline register: reset > flush > stall > normal capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_rd         <= '0;
      out_store_data <= '0;
      ctrl_q         <= '0;
      flags          <= 4'b0000;
      commit_count   <= '0;
    end else if (flush) begin
      // Squash only the valid/control side; data, flags and count hold.
      out_valid <= 1'b0;
      ctrl_q    <= '0;
    end else if (!stall) begin
      out_valid      <= in_valid;
      out_result     <= result;
      out_rd         <= rd;
      out_store_data <= store_data;
      ctrl_q         <= ctrl_in;
      if (flag_upd) flags <= nzcv_in;
      if (in_valid) commit_count <= commit_count + 1'b1;
    end
  end

  assign out_reg_write  = ctrl_q.reg_write;
  assign out_mem_read   = ctrl_q.mem_read;
  assign out_mem_write  = ctrl_q.mem_write;
  assign out_mem_to_reg = ctrl_q.mem_to_reg;

  // Same-cycle flag bypass for B.cond; stall does not affect what EX sees.
  always_comb begin
    flags_fwd = flags;
    if (flag_upd && !flush && !reset) flags_fwd = nzcv_in;
  end

endmodule

// File: tb/tb_ex_mem_latch.sv
// Directed bench for ex_mem_latch: reset, capture, stall, flush, bubbles,
// flag bypass and commit counter wrap (COUNT_WIDTH=4).
module tb_ex_mem_latch;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, in_valid, stall, flush;
  logic [DW-1:0] result, store_data;
  logic          negative, zero, overflow, carry_out, set_flags;
  logic [AW-1:0] rd;
  logic          reg_write, mem_read, mem_write, mem_to_reg;
  logic          out_valid, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg;
  logic [DW-1:0] out_result, out_store_data;
  logic [AW-1:0] out_rd;
  logic [3:0]    flags, flags_fwd;
  logic [CW-1:0] commit_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_mem_latch #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .result(result), .negative(negative), .zero(zero), .overflow(overflow),
    .carry_out(carry_out), .set_flags(set_flags), .rd(rd),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .store_data(store_data),
    .out_valid(out_valid), .out_result(out_result), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
    .out_store_data(out_store_data), .flags(flags), .flags_fwd(flags_fwd),
    .commit_count(commit_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; stall = 0; flush = 0; result = '0; store_data = '0;
    negative = 0; zero = 0; overflow = 0; carry_out = 0; set_flags = 0;
    rd = '0; reg_write = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0;
  endtask

  initial begin
    idle_inputs();
    // Reset held two cycles with live-looking inputs.
    reset = 1; in_valid = 1; result = 64'hFFFF; reg_write = 1;
    tick(); tick();
    chk("rst_valid",  out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_rwrite", out_reg_write, 0);
    chk("rst_flags",  flags, 4'b0000);
    chk("rst_count",  commit_count, 0);

    // Flag-setting instruction with zero result.
    reset = 0; idle_inputs();
    in_valid = 1; result = 64'h0; zero = 1; set_flags = 1; rd = 5; reg_write = 1;
    #1;
    chk("fwd_zero", flags_fwd, 4'b0100);
    tick();
    chk("t2_valid",  out_valid, 1);
    chk("t2_result", out_result, 0);
    chk("t2_rd",     out_rd, 5);
    chk("t2_rwrite", out_reg_write, 1);
    chk("t2_flags",  flags, 4'b0100);
    chk("t2_count",  commit_count, 1);

    // Load with store data, no flag update.
    idle_inputs();
    in_valid = 1; result = 64'hA5; mem_read = 1; mem_to_reg = 1; store_data = 64'hDEAD_BEEF; rd = 7;
    tick();
    chk("ld_result", out_result, 64'hA5);
    chk("ld_mread",  out_mem_read, 1);
    chk("ld_m2r",    out_mem_to_reg, 1);
    chk("ld_sdata",  out_store_data, 64'hDEAD_BEEF);
    chk("ld_flags",  flags, 4'b0100);
    chk("ld_count",  commit_count, 2);

    // Stall three cycles with a new flag-setting instruction waiting.
    idle_inputs();
    in_valid = 1; stall = 1; result = 64'h5A; set_flags = 1; negative = 1; reg_write = 1;
    #1;
    chk("stall_fwd", flags_fwd, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_result", out_result, 64'hA5);
      chk("stall_flags",  flags, 4'b0100);
      chk("stall_count",  commit_count, 2);
    end
    stall = 0;
    tick();
    chk("unstall_result", out_result, 64'h5A);
    chk("unstall_flags",  flags, 4'b1000);
    chk("unstall_count",  commit_count, 3);

    // Flush together with stall: flush wins, flags/count/data hold.
    idle_inputs();
    flush = 1; stall = 1; in_valid = 1; mem_write = 1; reg_write = 1;
    set_flags = 1; negative = 0; zero = 1; carry_out = 1; result = 64'h77;
    #1;
    chk("flush_fwd", flags_fwd, 4'b1000);
    tick();
    chk("flush_valid",  out_valid, 0);
    chk("flush_mwrite", out_mem_write, 0);
    chk("flush_rwrite", out_reg_write, 0);
    chk("flush_result", out_result, 64'h5A);
    chk("flush_flags",  flags, 4'b1000);
    chk("flush_count",  commit_count, 3);

    // Bubble with control bits asserted.
    idle_inputs();
    set_flags = 1; reg_write = 1; mem_read = 1; zero = 1;
    #1;
    chk("bub_fwd", flags_fwd, 4'b1000);
    tick();
    chk("bub_valid",  out_valid, 0);
    chk("bub_rwrite", out_reg_write, 0);
    chk("bub_mread",  out_mem_read, 0);
    chk("bub_flags",  flags, 4'b1000);
    chk("bub_count",  commit_count, 3);

    // Counter wrap: reset, 15 valid cycles to all-ones, one more to 0.
    idle_inputs();
    reset = 1; tick(); reset = 0;
    in_valid = 1;
    for (int i = 0; i < 15; i++) tick();
    chk("cnt_full", commit_count, 4'hF);
    set_flags = 1; carry_out = 1; overflow = 1;
    tick();
    chk("cnt_wrap",  commit_count, 0);
    chk("cv_flags",  flags, 4'b0011);

    // Reset mid-operation with stall and flush both asserted.
    reset = 1; stall = 1; flush = 1; result = 64'h1234;
    #1;
    chk("rst_fwd", flags_fwd, 4'b0011);
    tick();
    chk("mrst_valid", out_valid, 0);
    chk("mrst_flags", flags, 0);
    chk("mrst_count", commit_count, 0);
    chk("mrst_result", out_result, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
